// File: rtl/undo_log_writer_pkg.sv
// Shared types and constants for the undo-log writer slice.
package undo_log_writer_pkg;

    localparam int unsigned SLOT_W               = 6;
    localparam int unsigned ID_W                 = 4;
    localparam int unsigned UNDO_LOG_ENTRY_BYTES = 8;
    localparam int unsigned AXI_ADDR_W           = 64;
    localparam int unsigned AXI_DATA_W           = 64;
    localparam int unsigned AXI_STRB_W           = AXI_DATA_W / 8;

    typedef logic [ID_W-1:0]   undo_id_t;
    typedef logic [SLOT_W-1:0] cq_slice_slot_t;

    typedef struct packed {
        cq_slice_slot_t slot;
        undo_id_t       id;
        logic [31:0]    addr;
        logic [31:0]    data;
    } undo_log_rec_t;

    typedef enum logic [0:0] {
        UL_IDLE = 1'b0,
        UL_SEND = 1'b1
    } ul_state_t;

    // Byte address of a record inside the per-slot undo-log region.
    function automatic logic [AXI_ADDR_W-1:0] undo_log_byte_addr(
        input logic [AXI_ADDR_W-1:0] base,
        input cq_slice_slot_t        slot,
        input undo_id_t              id
    );
        return base + (AXI_ADDR_W'({slot, id}) * AXI_ADDR_W'(UNDO_LOG_ENTRY_BYTES));
    endfunction

endpackage

// File: rtl/undo_log_writer_if.sv
// Single-beat AXI write channel bundle used by the undo-log writer.
interface undo_log_writer_if;
    import undo_log_writer_pkg::*;

    logic                  m_awvalid;
    logic                  m_awready;
    logic [AXI_ADDR_W-1:0] m_awaddr;
    logic                  m_wvalid;
    logic                  m_wready;
    logic [AXI_DATA_W-1:0] m_wdata;
    logic [AXI_STRB_W-1:0] m_wstrb;
    logic                  m_wlast;
    logic                  m_bvalid;
    logic                  m_bready;
    logic [1:0]            m_bresp;

    modport master (
        output m_awvalid, m_awaddr, m_wvalid, m_wdata, m_wstrb, m_wlast, m_bready,
        input  m_awready, m_wready, m_bvalid, m_bresp
    );

    modport slave (
        input  m_awvalid, m_awaddr, m_wvalid, m_wdata, m_wstrb, m_wlast, m_bready,
        output m_awready, m_wready, m_bvalid, m_bresp
    );

endinterface

// File: rtl/undo_log_fifo.sv
// Synchronous record FIFO with registered full/empty and same-cycle push+pop.
module undo_log_fifo
    import undo_log_writer_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  undo_log_rec_t push_data,
    input  logic          pop,
    output undo_log_rec_t pop_data,
    output logic          full,
    output logic          empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    undo_log_rec_t    mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             do_push_c;
    logic             do_pop_c;

    // Qualify push/pop; a push into a full FIFO is allowed only alongside a pop.
    always_comb begin
        do_pop_c  = pop & ~empty;
        do_push_c = push & (~full | do_pop_c);
        count_d   = count_q;
        if (do_push_c && !do_pop_c) begin
            count_d = count_q + CNT_W'(1);
        end else if (!do_push_c && do_pop_c) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Pointers, occupancy and registered flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
        end else begin
            if (do_push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
            full    <= (count_d == CNT_W'(DEPTH));
            empty   <= (count_d == '0);
        end
    end

    // Storage array; contents need no reset since empty gates every read.
    always_ff @(posedge clk) begin
        if (do_push_c) mem[wr_ptr_q] <= push_data;
    end

    assign pop_data = mem[rd_ptr_q];

endmodule

// File: rtl/undo_log_writer.sv
// Undo-log writer: buffers core undo records and writes each as one 64-bit
// AXI beat into the per-slot log region; tracks in-flight writes for flush.
// Optional statistics counters are built when UNDO_LOG_WRITER_STATS_EN is defined.
module undo_log_writer
    import undo_log_writer_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned MAX_OUTSTANDING = 8,
    parameter logic [63:0] BASE_ADDR       = 64'h0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    undo_log_valid,
    output logic                    undo_log_ready,
    input  undo_id_t                undo_log_id,
    input  cq_slice_slot_t          undo_log_slot,
    input  logic [31:0]             undo_log_addr,
    input  logic [31:0]             undo_log_data,
    undo_log_writer_if.master       axi,
    input  logic                    flush_valid,
    output logic                    flush_ready,
    output logic                    busy,
    output logic                    err,
    output logic [31:0]             stat_writes,
    output logic [31:0]             stat_full_cycles,
    output logic [3:0]              stat_max_outstanding
);

    localparam int unsigned OST_W = $clog2(MAX_OUTSTANDING + 1);

    ul_state_t             state_q;
    ul_state_t             state_d;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_push_c;
    logic                  fifo_pop_c;
    undo_log_rec_t         in_rec;
    undo_log_rec_t         head_rec;
    logic                  awvalid_q;
    logic                  awvalid_d;
    logic                  wvalid_q;
    logic                  wvalid_d;
    logic [AXI_ADDR_W-1:0] awaddr_q;
    logic [AXI_DATA_W-1:0] wdata_q;
    logic                  aw_done_c;
    logic                  w_done_c;
    logic                  aw_hs_c;
    logic                  b_spur_c;
    logic [OST_W-1:0]      ost_q;
    logic [OST_W-1:0]      ost_d;
    logic                  err_q;

    assign undo_log_ready = ~fifo_full & ~rst;
    assign fifo_push_c    = undo_log_valid & undo_log_ready;
    assign in_rec         = '{slot: undo_log_slot, id: undo_log_id,
                              addr: undo_log_addr, data: undo_log_data};

    undo_log_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push_c),
        .push_data (in_rec),
        .pop       (fifo_pop_c),
        .pop_data  (head_rec),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= UL_IDLE;
        else     state_q <= state_d;
    end

    // Next state: issue from IDLE when a record and a credit exist; SEND waits
    // for both AW and W, which may complete in either order or together.
    always_comb begin
        state_d    = state_q;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        fifo_pop_c = 1'b0;
        aw_done_c  = ~awvalid_q | axi.m_awready;
        w_done_c   = ~wvalid_q | axi.m_wready;
        case (state_q)
            UL_IDLE: begin
                if (!fifo_empty && (ost_q < OST_W'(MAX_OUTSTANDING))) begin
                    fifo_pop_c = 1'b1;
                    awvalid_d  = 1'b1;
                    wvalid_d   = 1'b1;
                    state_d    = UL_SEND;
                end
            end
            UL_SEND: begin
                if (aw_done_c) awvalid_d = 1'b0;
                if (w_done_c)  wvalid_d  = 1'b0;
                if (aw_done_c && w_done_c) state_d = UL_IDLE;
            end
            default: state_d = UL_IDLE;
        endcase
    end

    // AXI channel valids and the popped record's address/data.
    always_ff @(posedge clk) begin
        if (rst) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
        end else begin
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            if (fifo_pop_c) begin
                awaddr_q <= undo_log_byte_addr(BASE_ADDR, head_rec.slot, head_rec.id);
                wdata_q  <= {head_rec.data, head_rec.addr};
            end
        end
    end

    // Outstanding count: +1 per AW handshake, -1 per B; a B with nothing in flight is spurious.
    always_comb begin
        aw_hs_c  = awvalid_q & axi.m_awready;
        ost_d    = ost_q;
        b_spur_c = 1'b0;
        case ({aw_hs_c, axi.m_bvalid})
            2'b10: ost_d = ost_q + OST_W'(1);
            2'b01: begin
                if (ost_q == '0) b_spur_c = 1'b1;
                else             ost_d    = ost_q - OST_W'(1);
            end
            default: ost_d = ost_q;
        endcase
    end

    // Outstanding counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            ost_q <= '0;
            err_q <= 1'b0;
        end else begin
            ost_q <= ost_d;
            err_q <= err_q | b_spur_c | (axi.m_bvalid & (axi.m_bresp != 2'b00));
        end
    end

    assign busy        = ~fifo_empty | (state_q == UL_SEND) | (ost_q != '0);
    assign flush_ready = flush_valid & ~busy;
    assign err         = err_q;

    assign axi.m_awvalid = awvalid_q;
    assign axi.m_awaddr  = awaddr_q;
    assign axi.m_wvalid  = wvalid_q;
    assign axi.m_wdata   = wdata_q;
    assign axi.m_wstrb   = '1;
    assign axi.m_wlast   = 1'b1;
    assign axi.m_bready  = 1'b1;

`ifdef UNDO_LOG_WRITER_STATS_EN
    logic [31:0] st_writes_q;
    logic [31:0] st_full_q;
    logic [3:0]  st_max_q;
    logic [3:0]  ost_hw_c;

    // Outstanding level clipped to the 4-bit high-water field.
    always_comb begin
        ost_hw_c = (32'(ost_d) > 32'd15) ? 4'hF : 4'(ost_d);
    end

    // Saturating statistics counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_writes_q <= '0;
            st_full_q   <= '0;
            st_max_q    <= '0;
        end else begin
            if (axi.m_bvalid && (st_writes_q != '1)) st_writes_q <= st_writes_q + 32'd1;
            if (undo_log_valid && !undo_log_ready && (st_full_q != '1)) st_full_q <= st_full_q + 32'd1;
            if (ost_hw_c > st_max_q) st_max_q <= ost_hw_c;
        end
    end

    assign stat_writes          = st_writes_q;
    assign stat_full_cycles     = st_full_q;
    assign stat_max_outstanding = st_max_q;
`else
    assign stat_writes          = '0;
    assign stat_full_cycles     = '0;
    assign stat_max_outstanding = '0;
`endif

endmodule

// File: tb/tb_undo_log_writer.sv
// Directed bench for undo_log_writer: vector table plus multi-cycle sequences.
module tb_undo_log_writer;
    import undo_log_writer_pkg::*;

    logic           clk = 1'b0;
    logic           rst;
    logic           ul_valid;
    logic           ul_ready;
    undo_id_t       ul_id;
    cq_slice_slot_t ul_slot;
    logic [31:0]    ul_addr;
    logic [31:0]    ul_data;
    logic           flush_valid;
    logic           flush_ready;
    logic           busy;
    logic           err;
    logic [31:0]    stat_writes;
    logic [31:0]    stat_full_cycles;
    logic [3:0]     stat_max;

    undo_log_writer_if ax();

    undo_log_writer #(
        .FIFO_DEPTH      (4),
        .MAX_OUTSTANDING (2),
        .BASE_ADDR       (64'h0)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .undo_log_valid       (ul_valid),
        .undo_log_ready       (ul_ready),
        .undo_log_id          (ul_id),
        .undo_log_slot        (ul_slot),
        .undo_log_addr        (ul_addr),
        .undo_log_data        (ul_data),
        .axi                  (ax),
        .flush_valid          (flush_valid),
        .flush_ready          (flush_ready),
        .busy                 (busy),
        .err                  (err),
        .stat_writes          (stat_writes),
        .stat_full_cycles     (stat_full_cycles),
        .stat_max_outstanding (stat_max)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Handshake monitor.
    logic [63:0] aw_log[$];
    logic [63:0] w_log[$];
    int aw_cnt = 0;
    int w_cnt  = 0;
    always @(posedge clk) begin
        if (ax.m_awvalid && ax.m_awready) begin aw_log.push_back(ax.m_awaddr); aw_cnt++; end
        if (ax.m_wvalid && ax.m_wready)   begin w_log.push_back(ax.m_wdata);   w_cnt++;  end
    end

    // B responder: one response per completed AW, automatic or on request; or a spurious beat.
    logic       b_auto;
    logic       b_pulse;
    logic       b_spur;
    logic [1:0] b_resp_val;
    logic       resp_bv;
    int         b_cnt = 0;
    always @(negedge clk) begin
        resp_bv = 1'b0;
        if (b_spur) resp_bv = 1'b1;
        else if ((b_auto || b_pulse) && (aw_cnt > b_cnt)) begin
            resp_bv = 1'b1;
            b_cnt++;
        end
        ax.m_bvalid = resp_bv;
        ax.m_bresp  = resp_bv ? b_resp_val : 2'b00;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int slot, input int id, input logic [31:0] a,
                        input logic [31:0] d, input int bound, output bit ok);
        ul_valid = 1'b1;
        ul_slot  = cq_slice_slot_t'(slot);
        ul_id    = undo_id_t'(id);
        ul_addr  = a;
        ul_data  = d;
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (ul_ready) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        ul_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int bound);
        int i;
        i = 0;
        while (busy && i < bound) begin tick(); i++; end
        check(name, 64'(busy), 64'h0);
    endtask

    task automatic wait_awvalid(input string name, input int bound);
        int i;
        i = 0;
        while (!ax.m_awvalid && i < bound) begin tick(); i++; end
        check(name, 64'(ax.m_awvalid), 64'h1);
    endtask

    task automatic wait_aw_cnt(input string name, input int target, input int bound);
        int i;
        i = 0;
        while (aw_cnt < target && i < bound) begin tick(); i++; end
        check_int(name, aw_cnt, target);
    endtask

    typedef struct {
        int          slot;
        int          id;
        logic [31:0] addr;
        logic [31:0] data;
        logic [63:0] exp_awaddr;
        logic [63:0] exp_wdata;
    } vec_t;

    vec_t vecs[5];

    initial begin
        bit ok;
        int acc;
        int abase;
        int wbase;

        vecs[0] = '{0,  0,  32'h0000_0000, 32'h0000_0000, 64'h0000,   64'h00000000_00000000};
        vecs[1] = '{63, 15, 32'hFFFF_FFFF, 32'h1234_5678, 64'h1FF8,   64'h12345678_FFFFFFFF};
        vecs[2] = '{1,  0,  32'hDEAD_0000, 32'hCAFE_BABE, 64'h0080,   64'hCAFEBABE_DEAD0000};
        vecs[3] = '{0,  1,  32'h0000_0004, 32'h0000_0008, 64'h0008,   64'h00000008_00000004};
        vecs[4] = '{42, 9,  32'h8000_0001, 32'h0000_FFFF, 64'h1548,   64'h0000FFFF_80000001};

        rst = 1'b1; ul_valid = 1'b0; ul_id = '0; ul_slot = '0; ul_addr = '0; ul_data = '0;
        flush_valid = 1'b0;
        ax.m_awready = 1'b0; ax.m_wready = 1'b0;
        b_auto = 1'b1; b_pulse = 1'b0; b_spur = 1'b0; b_resp_val = 2'b00;

        // Reset state.
        repeat (3) tick();
        check("rst_ready_low", 64'(ul_ready), 64'h0);
        rst = 1'b0;
        #1;
        check("rst_ready", 64'(ul_ready), 64'h1);
        check("rst_awvalid", 64'(ax.m_awvalid), 64'h0);
        check("rst_wvalid", 64'(ax.m_wvalid), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_err", 64'(err), 64'h0);
        check("rst_flush_ready", 64'(flush_ready), 64'h0);
        flush_valid = 1'b1;
        #1;
        check("idle_flush_ready", 64'(flush_ready), 64'h1);
        flush_valid = 1'b0;
        check("rst_stat_writes", 64'(stat_writes), 64'h0);

        // Single record: latency, address/data packing, flush after B.
        ax.m_awready = 1'b1; ax.m_wready = 1'b1;
        abase = aw_cnt;
        push(3, 2, 32'h100, 32'hAB, 4, ok);
        check_int("t1_accept", int'(ok), 1);
        check("t1_aw_not_yet", 64'(ax.m_awvalid), 64'h0);
        tick();
        check("t1_awvalid", 64'(ax.m_awvalid), 64'h1);
        check("t1_wvalid", 64'(ax.m_wvalid), 64'h1);
        check("t1_awaddr", ax.m_awaddr, 64'h190);
        check("t1_wdata", ax.m_wdata, 64'h000000AB_00000100);
        check("t1_wstrb", 64'(ax.m_wstrb), 64'hFF);
        check("t1_wlast", 64'(ax.m_wlast), 64'h1);
        check("t1_bready", 64'(ax.m_bready), 64'h1);
        flush_valid = 1'b1;
        #1;
        check("t1_flush_busy", 64'(flush_ready), 64'h0);
        tick();
        check("t1_aw_dropped", 64'(ax.m_awvalid), 64'h0);
        check("t1_flush_wait_b", 64'(flush_ready), 64'h0);
        tick();
        check("t1_flush_ready", 64'(flush_ready), 64'h1);
        flush_valid = 1'b0;
        check_int("t1_aw_count", aw_cnt - abase, 1);

        // Vector table.
        for (int v = 0; v < 5; v++) begin
            push(vecs[v].slot, vecs[v].id, vecs[v].addr, vecs[v].data, 8, ok);
            check_int($sformatf("vec%0d_accept", v), int'(ok), 1);
            wait_awvalid($sformatf("vec%0d_awvalid", v), 8);
            check($sformatf("vec%0d_awaddr", v), ax.m_awaddr, vecs[v].exp_awaddr);
            check($sformatf("vec%0d_wdata", v), ax.m_wdata, vecs[v].exp_wdata);
            wait_idle($sformatf("vec%0d_idle", v), 20);
        end

        // Back-pressure: AW/W stalled, FIFO fills behind the record in SEND.
        ax.m_awready = 1'b0; ax.m_wready = 1'b0;
        abase = aw_cnt; wbase = w_cnt; acc = 0;
        for (int i = 0; i < 5; i++) begin
            push(5, i, 32'h1000 + 32'(i), 32'hA0 + 32'(i), 1, ok);
            acc += int'(ok);
        end
        check_int("bp_accepted", acc, 5);
        check("bp_ready_low", 64'(ul_ready), 64'h0);
        push(5, 5, 32'h1005, 32'hA5, 1, ok);
        check_int("bp_sixth_rejected", int'(ok), 0);
        check("bp_awvalid_held", 64'(ax.m_awvalid), 64'h1);
        ax.m_awready = 1'b1; ax.m_wready = 1'b1;
        wait_idle("bp_drain", 80);
        check_int("bp_aw_count", aw_cnt - abase, 5);
        check_int("bp_w_count", w_cnt - wbase, 5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_awaddr%0d", i), aw_log[abase + i], 64'h280 + 64'(8 * i));
            check($sformatf("bp_wdata%0d", i), w_log[wbase + i],
                  {32'hA0 + 32'(i), 32'h1000 + 32'(i)});
        end

        // Outstanding limit of 2 with B withheld.
        b_auto = 1'b0;
        abase = aw_cnt;
        for (int i = 0; i < 4; i++) push(7, i, 32'h2000 + 32'(i), 32'hB0 + 32'(i), 4, ok);
        repeat (10) tick();
        check_int("ost_parked_count", aw_cnt - abase, 2);
        check("ost_parked_awvalid", 64'(ax.m_awvalid), 64'h0);
        check("ost_parked_busy", 64'(busy), 64'h1);
        b_pulse = 1'b1;
        tick();
        b_pulse = 1'b0;
        wait_aw_cnt("ost_third_issue", abase + 3, 10);
        repeat (5) tick();
        check_int("ost_parked_again", aw_cnt - abase, 3);
        check("ost_third_addr", aw_log[abase + 2], 64'h390);
        b_auto = 1'b1;
        wait_idle("ost_drain", 40);
        check_int("ost_total", aw_cnt - abase, 4);
        check("ost_err", 64'(err), 64'h0);

        // W completes three cycles before AW: single W, stays in SEND until AW.
        ax.m_awready = 1'b0; ax.m_wready = 1'b1;
        abase = aw_cnt; wbase = w_cnt;
        push(1, 1, 32'h55, 32'h66, 4, ok);
        tick();
        check("wfirst_wvalid", 64'(ax.m_wvalid), 64'h1);
        tick();
        check("wfirst_w_dropped", 64'(ax.m_wvalid), 64'h0);
        check("wfirst_aw_held", 64'(ax.m_awvalid), 64'h1);
        repeat (2) tick();
        check("wfirst_aw_still", 64'(ax.m_awvalid), 64'h1);
        check("wfirst_no_new_w", 64'(ax.m_wvalid), 64'h0);
        check_int("wfirst_w_once", w_cnt - wbase, 1);
        ax.m_awready = 1'b1;
        tick();
        check("wfirst_aw_done", 64'(ax.m_awvalid), 64'h0);
        check_int("wfirst_aw_count", aw_cnt - abase, 1);
        wait_idle("wfirst_idle", 20);
        check_int("wfirst_w_total", w_cnt - wbase, 1);

        // Error response is sticky.
        push(2, 0, 32'h10, 32'h20, 4, ok);
        wait_idle("err_ok_idle", 20);
        check("err_after_okay", 64'(err), 64'h0);
        b_resp_val = 2'b10;
        push(2, 1, 32'h11, 32'h21, 4, ok);
        wait_idle("err_slv_idle", 20);
        check("err_after_slverr", 64'(err), 64'h1);
        b_resp_val = 2'b00;
        push(2, 2, 32'h12, 32'h22, 4, ok);
        wait_idle("err_sticky_idle", 20);
        check("err_sticky", 64'(err), 64'h1);

        // Reset while in SEND with three records queued.
        ax.m_awready = 1'b0; ax.m_wready = 1'b0;
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            push(9, i, 32'h300 + 32'(i), 32'h400 + 32'(i), 2, ok);
            acc += int'(ok);
        end
        check_int("mrst_accepted", acc, 4);
        check("mrst_pre_awvalid", 64'(ax.m_awvalid), 64'h1);
        rst = 1'b1;
        #1;
        check("mrst_ready_low", 64'(ul_ready), 64'h0);
        tick();
        check("mrst_awvalid", 64'(ax.m_awvalid), 64'h0);
        check("mrst_wvalid", 64'(ax.m_wvalid), 64'h0);
        check("mrst_busy", 64'(busy), 64'h0);
        check("mrst_err_clear", 64'(err), 64'h0);
        rst = 1'b0;
        #1;
        check("mrst_ready", 64'(ul_ready), 64'h1);
        check("mrst_stat_writes", 64'(stat_writes), 64'h0);
        check("mrst_stat_full", 64'(stat_full_cycles), 64'h0);
        check("mrst_stat_max", 64'(stat_max), 64'h0);

        // Spurious B with nothing outstanding.
        b_spur = 1'b1;
        tick();
        b_spur = 1'b0;
        check("spur_err", 64'(err), 64'h1);
        check("spur_busy", 64'(busy), 64'h0);
        tick();
        check("spur_busy_after", 64'(busy), 64'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
